sys_unstacker: RTL and testbench
================================

# sys_unstacker

Serialiser feeding a word-serial `sys_*` stage from a lane-packed vector stage. It accepts one packed vector of `NumOfNerves/DepthIn` words under a valid/ready handshake. It then emits the words one per cycle, highest lane first, with `out_start` marking frame boundaries. It is the inverse of the stacking stage, so the two round-trip data and start markers losslessly.

## Interface
- `BitSize`, 8, width of one word.
- `NumOfNerves`, 4, total words per frame across all depths; must be divisible by `DepthIn`.
- `DepthIn`, 2, depth factor; lane count `WIDTH = NumOfNerves/DepthIn` (≥1).
- `clk`  input  1  clock, rising edge.
- `res_n`  input  1  reset; asynchronous, active-low.
- `in_valid`  input  1  packed vector present.
- `in_start`  input  1  vector is the first of a frame; qualified by `in_valid`.
- `in_data`  input  `[WIDTH-1:0][BitSize-1:0]`  packed vector; lane `WIDTH-1` is the first word.
- `in_ready`  output  1  vector accepted when `in_valid && in_ready`.
- `out_valid`  output  1  `out_data` holds a word.
- `out_ready`  input  1  word consumed when `out_valid && out_ready`.
- `out_start`  output  1  current word is lane `WIDTH-1` of a vector accepted with `in_start=1`.
- `out_data`  output  `BitSize`  serial word.
- `out_last`  output  1  present only with `SYS_UNSTACKER_LAST_EN`.

## Operation
- State `IDLE`: no vector held. `in_ready=1`, `out_valid=0`.
- State `SHIFT`: a vector is held in `vec_r`, with lane index `idx_r` and captured start flag `start_r`.
- Accept (`in_valid && in_ready`):
  - capture `in_data` into `vec_r` and `in_start` into `start_r`
  - set `idx_r=WIDTH-1`
  - enter/stay in `SHIFT`.
- Outputs in `SHIFT`:
  - `out_data = vec_r[idx_r]`
  - `out_valid = 1`
  - `out_start = start_r && (idx_r==WIDTH-1)`.
- Word transfer (`out_valid && out_ready`):
  - if `idx_r>0`, decrement `idx_r`
  - if `idx_r==0` (last word) and there is no simultaneous accept, go to `IDLE`.
- `in_ready = (state==IDLE) || (idx_r==0 && out_ready)`. This allows a back-to-back vector with no bubble: the last-word transfer and the new accept occur in the same cycle, and the accept wins.
- Stall: while `out_valid && !out_ready`, `out_data`, `out_start`, `idx_r` and `vec_r` are held stable.
- `in_start` with `in_valid=0` is ignored.
- `WIDTH==1`: `idx_r` is constant 0. Every vector is one word; `in_ready = !out_valid || out_ready`.
- Counter width is `max(1,$clog2(WIDTH))`. `idx_r` never wraps below 0.
- Reset asserted mid-vector: the partial vector is discarded, with no resume after release.

## Timing
- All outputs except `in_ready` are registered. `in_ready` is combinational from state, `idx_r` and `out_ready`.
- Reset values: state `IDLE`, `out_valid=0`, `out_start=0`, `out_data=0`, `out_last=0`, `in_ready=1` (after reset).
- Reset effect on `out_valid` is immediate on assertion, independent of `clk`.
- Latency: vector accepted at edge N gives its first word valid after edge N; word k (0-based) appears after edge N+k when `out_ready` is held high.
- Throughput: 1 word/cycle sustained; one vector per `WIDTH` cycles.

## Configuration
- `SYS_UNSTACKER_LAST_EN` defined:
  - adds port `out_last`
  - `out_last = out_valid && idx_r==0`, held during stalls
  - reset value 0.
- `SYS_UNSTACKER_LAST_EN` undefined: the port and its logic are absent. Behaviour is otherwise identical.

## Structure
- Shared package `sys_pkg` holds:
  - `typedef enum logic {IDLE, SHIFT} unstack_state_t`
  - a `function automatic int sys_lanes(int nerves, int depth)` returning `nerves/depth`, shared with the stacking stage.
- No sub-module: counter, FSM and vector register stay in one module.

## Test plan
- Reset: hold `res_n=0` mid-`SHIFT` -> `out_valid` drops immediately; after release `in_ready=1`, `out_valid=0`.
- Single vector (W=2): `in_data={8'hAA,8'h55}`, `in_start=1`, `out_ready=1` -> `AA` with `out_start=1`, then `55` with `out_start=0`, then `IDLE`.
- Back-to-back: `{01,02}` then `{03,04}` with `in_valid` held -> `01,02,03,04` on 4 consecutive cycles, no bubble; `in_ready` high on the `02` cycle.
- Backpressure: `out_ready=0` for 3 cycles while `AA` is presented -> `AA` stable, `in_ready=0`; release -> `55` next cycle.
- `WIDTH=1` build (`NumOfNerves=4`, `DepthIn=4`): stream `10,11,12` -> one word per cycle, `out_start` only on words accepted with `in_start`.
- Round-trip: feed `sys_unstacker` output into the stacking stage -> the reconstructed vectors equal the inputs for 100 random vectors; with `SYS_UNSTACKER_LAST_EN`, `out_last` pulses on every second word.

Source files
------------

// File: rtl/sys_pkg.sv
// Shared definitions for the sys_* stacking/unstacking stages.
package sys_pkg;

  typedef enum logic {IDLE, SHIFT} unstack_state_t;

  function automatic int sys_lanes(int nerves, int depth);
    return nerves / depth;
  endfunction

endpackage

// File: rtl/sys_unstacker.sv
// Serialises one packed lane vector into words, highest lane first, one word per cycle.
// First word valid the cycle after accept; stalls hold all outputs; optional out_last via SYS_UNSTACKER_LAST_EN.
module sys_unstacker
  import sys_pkg::*;
#(
  parameter int BitSize     = 8,
  parameter int NumOfNerves = 4,
  parameter int DepthIn     = 2
) (
  input  logic                                                  clk,
  input  logic                                                  res_n,
  input  logic                                                  in_valid,
  input  logic                                                  in_start,
  input  logic [sys_lanes(NumOfNerves, DepthIn)-1:0][BitSize-1:0] in_data,
  output logic                                                  in_ready,
  output logic                                                  out_valid,
  input  logic                                                  out_ready,
  output logic                                                  out_start,
  output logic [BitSize-1:0]                                    out_data
`ifdef SYS_UNSTACKER_LAST_EN
  ,
  output logic                                                  out_last
`endif
);

  localparam int WIDTH = sys_lanes(NumOfNerves, DepthIn);
  localparam int IW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] IDX_TOP = IW'(WIDTH - 1);

  unstack_state_t                r_state;
  unstack_state_t                w_state_nxt;
  logic [WIDTH-1:0][BitSize-1:0] r_vec;
  logic [IW-1:0]                 r_idx;
  logic [IW-1:0]                 w_idx_dec;
  logic                          w_last_word;
  logic                          w_accept;
  logic                          w_xfer;

  assign w_last_word = (r_idx == '0);
  assign w_idx_dec   = r_idx - 1'b1;
  // Last-word transfer and a new accept may coincide, giving back-to-back vectors.
  assign in_ready    = (r_state == IDLE) || (w_last_word && out_ready);
  assign w_accept    = in_valid && in_ready;
  assign w_xfer      = out_valid && out_ready;

  always_comb begin
    w_state_nxt = r_state;
    if (w_accept) begin
      w_state_nxt = SHIFT;
    end else if (w_xfer && w_last_word) begin
      w_state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_vec     <= '0;
      r_idx     <= '0;
      out_valid <= 1'b0;
      out_start <= 1'b0;
      out_data  <= '0;
    end else if (w_accept) begin
      r_vec     <= in_data;
      r_idx     <= IDX_TOP;
      out_valid <= 1'b1;
      out_start <= in_start;
      out_data  <= in_data[WIDTH-1];
    end else if (w_xfer) begin
      out_start <= 1'b0;
      if (!w_last_word) begin
        r_idx    <= w_idx_dec;
        out_data <= r_vec[w_idx_dec];
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef SYS_UNSTACKER_LAST_EN
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      out_last <= 1'b0;
    end else if (w_accept) begin
      out_last <= (IDX_TOP == '0);
    end else if (w_xfer) begin
      out_last <= !w_last_word && (w_idx_dec == '0);
    end
  end
`endif

endmodule

// File: tb/tb_sys_unstacker.sv
// Directed and round-trip bench for sys_unstacker (W=2 main instance, W=1 second instance).
module tb_sys_unstacker;

  logic            clk = 1'b0;
  logic            res_n;
  logic            in_valid, in_start, in_ready;
  logic [1:0][7:0] in_data;
  logic            out_valid, out_ready, out_start;
  logic [7:0]      out_data;
  logic            out_last;
  logic            w1_in_valid, w1_in_start, w1_in_ready;
  logic [0:0][7:0] w1_in_data;
  logic            w1_out_valid, w1_out_ready, w1_out_start;
  logic [7:0]      w1_out_data;
  logic            w1_out_last;
  int              checks = 0;
  int              errors = 0;

  always #5 clk = ~clk;

  sys_unstacker #(.BitSize(8), .NumOfNerves(4), .DepthIn(2)) dut (
    .clk(clk), .res_n(res_n), .in_valid(in_valid), .in_start(in_start), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready), .out_start(out_start),
    .out_data(out_data)
`ifdef SYS_UNSTACKER_LAST_EN
    , .out_last(out_last)
`endif
  );

  sys_unstacker #(.BitSize(8), .NumOfNerves(4), .DepthIn(4)) dut_w1 (
    .clk(clk), .res_n(res_n), .in_valid(w1_in_valid), .in_start(w1_in_start), .in_data(w1_in_data),
    .in_ready(w1_in_ready), .out_valid(w1_out_valid), .out_ready(w1_out_ready), .out_start(w1_out_start),
    .out_data(w1_out_data)
`ifdef SYS_UNSTACKER_LAST_EN
    , .out_last(w1_out_last)
`endif
  );

`ifndef SYS_UNSTACKER_LAST_EN
  assign out_last    = 1'b0;
  assign w1_out_last = 1'b0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    res_n = 1'b0; in_valid = 0; in_start = 0; in_data = '0; out_ready = 0;
    w1_in_valid = 0; w1_in_start = 0; w1_in_data = '0; w1_out_ready = 0;
    repeat (2) @(posedge clk);
    #2 res_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL rst_out_data got %h want 00", out_data); end
    checks++; if (out_start !== 1'b0) begin errors++; $display("FAIL rst_out_start got %b want 0", out_start); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last got %b want 0", out_last); end
    // Reset in the middle of a held vector.
    in_valid = 1; in_start = 1; in_data = {8'h12, 8'h34};
    tick();
    in_valid = 0; in_start = 0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_valid got %b want 1", out_valid); end
    #2 res_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid got %b want 0", out_valid); end
    @(posedge clk);
    #3 res_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_rel_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_rel_valid got %b want 0", out_valid); end
    // Start without valid must not create a word, and no resume of the discarded vector.
    out_ready = 1; in_start = 1;
    tick();
    in_start = 0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL start_no_valid got %b want 0", out_valid); end
  endtask

  task automatic test_single();
    out_ready = 1; in_valid = 1; in_start = 1; in_data = {8'hAA, 8'h55};
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready got %b want 1", in_ready); end
    tick();
    in_valid = 0; in_start = 0;
    checks++; if ({out_valid, out_start, out_data} !== {2'b11, 8'hAA}) begin errors++; $display("FAIL single_w0 got v%b s%b %h want v1 s1 aa", out_valid, out_start, out_data); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL single_w0_in_ready got %b want 0", in_ready); end
    tick();
    checks++; if ({out_valid, out_start, out_data} !== {2'b10, 8'h55}) begin errors++; $display("FAIL single_w1 got v%b s%b %h want v1 s0 55", out_valid, out_start, out_data); end
    checks++; if (out_last !== (`ifdef SYS_UNSTACKER_LAST_EN 1'b1 `else 1'b0 `endif)) begin errors++; $display("FAIL single_w1_last got %b", out_last); end
    tick();
    checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL single_idle got v%b r%b want v0 r1", out_valid, in_ready); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_d [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
    logic       exp_s [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    out_ready = 1; in_valid = 1; in_start = 1; in_data = {8'h01, 8'h02};
    tick();
    in_start = 0; in_data = {8'h03, 8'h04};
    for (int k = 0; k < 4; k++) begin
      checks++; if ({out_valid, out_start, out_data} !== {1'b1, exp_s[k], exp_d[k]}) begin errors++; $display("FAIL b2b_word%0d got v%b s%b %h want v1 s%b %h", k, out_valid, out_start, out_data, exp_s[k], exp_d[k]); end
      if (k == 1) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready got %b want 1", in_ready); end
      end
      if (k == 2) in_valid = 0;
      tick();
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 0; in_valid = 1; in_start = 1; in_data = {8'hAA, 8'h55};
    tick();
    in_valid = 0; in_start = 0;
    for (int k = 0; k < 3; k++) begin
      checks++; if ({out_valid, out_start, out_data, in_ready} !== {2'b11, 8'hAA, 1'b0}) begin errors++; $display("FAIL bp_stall%0d got v%b s%b %h r%b want v1 s1 aa r0", k, out_valid, out_start, out_data, in_ready); end
      tick();
    end
    out_ready = 1;
    #1;
    tick();
    checks++; if ({out_valid, out_start, out_data} !== {2'b10, 8'h55}) begin errors++; $display("FAIL bp_release got v%b s%b %h want v1 s0 55", out_valid, out_start, out_data); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_idle got %b want 0", out_valid); end
  endtask

  task automatic test_width1();
    logic [7:0] d [3] = '{8'h10, 8'h11, 8'h12};
    logic       s [3] = '{1'b1, 1'b0, 1'b1};
    w1_out_ready = 1; w1_in_valid = 1;
    for (int k = 0; k < 3; k++) begin
      w1_in_data[0] = d[k]; w1_in_start = s[k];
      #1;
      checks++; if (w1_in_ready !== 1'b1) begin errors++; $display("FAIL w1_in_ready%0d got %b want 1", k, w1_in_ready); end
      tick();
      checks++; if ({w1_out_valid, w1_out_start, w1_out_data} !== {1'b1, s[k], d[k]}) begin errors++; $display("FAIL w1_word%0d got v%b s%b %h want v1 s%b %h", k, w1_out_valid, w1_out_start, w1_out_data, s[k], d[k]); end
`ifdef SYS_UNSTACKER_LAST_EN
      checks++; if (w1_out_last !== 1'b1) begin errors++; $display("FAIL w1_last%0d got %b want 1", k, w1_out_last); end
`endif
    end
    w1_in_valid = 0; w1_in_start = 0;
    tick();
    checks++; if (w1_out_valid !== 1'b0) begin errors++; $display("FAIL w1_idle got %b want 0", w1_out_valid); end
  endtask

  task automatic test_round_trip();
    logic [1:0][7:0] q_vec [$];
    logic            q_st  [$];
    logic [1:0][7:0] asm_v;
    int              sent = 0;
    int              rcvd = 0;
    int              lane = 1;
    logic            acc;
    asm_v = '0;
    in_valid = 0; in_start = 0;
    for (int cyc = 0; cyc < 3000 && rcvd < 100; cyc++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid && sent < 100 && $urandom_range(0, 3) != 0) begin
        in_valid = 1;
        in_data  = 16'($urandom);
        in_start = ($urandom_range(0, 1) == 1);
      end
      #1;
      if (out_valid && out_ready) begin
        if (q_vec.size() == 0) begin
          checks++; errors++; $display("FAIL rt_unexpected_word got %h want none", out_data);
        end else begin
`ifdef SYS_UNSTACKER_LAST_EN
          checks++; if (out_last !== (lane == 0)) begin errors++; $display("FAIL rt_last got %b want %b", out_last, lane == 0); end
`endif
          if (lane == 1) begin
            checks++; if (out_start !== q_st[0]) begin errors++; $display("FAIL rt_start vec%0d got %b want %b", rcvd, out_start, q_st[0]); end
          end else if (out_start !== 1'b0) begin
            checks++; errors++; $display("FAIL rt_start_lane0 vec%0d got 1 want 0", rcvd);
          end
          asm_v[lane] = out_data;
          if (lane == 0) begin
            checks++; if (asm_v !== q_vec[0]) begin errors++; $display("FAIL rt_vec%0d got %h want %h", rcvd, asm_v, q_vec[0]); end
            void'(q_vec.pop_front()); void'(q_st.pop_front());
            rcvd++;
            lane = 1;
          end else begin
            lane = 0;
          end
        end
      end
      acc = in_valid && in_ready;
      if (acc) begin
        q_vec.push_back(in_data); q_st.push_back(in_start); sent++;
      end
      tick();
      if (acc) begin in_valid = 0; in_start = 0; end
    end
    checks++; if (rcvd != 100) begin errors++; $display("FAIL rt_count got %0d want 100", rcvd); end
    in_valid = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_width1();
    test_round_trip();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
